regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 4: cycles a pending external write may wait before a pipeline stall is requested.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_valid  in  1  writeback stage write request, meaning RegWrite from WB.
REQ-005 SHALL have ports wb_reg  in  5 and wb_data  in  32: the WB destination register and its write data.
REQ-006 SHALL have ports ext_valid  in  1 and ext_ready  out  1: the valid/ready handshake for the external writer (multi-cycle unit).
REQ-007 SHALL have ports ext_reg  in  5 and ext_data  in  32: the external writer's destination register and data.
REQ-008 SHALL have ports rf_we  out  1, rf_waddr  out  5 and rf_wdata  out  32: the register file write port (RegWrite, write_reg, write_data).
REQ-009 SHALL have ports pend_valid  out  1, pend_reg  out  5 and pend_data  out  32: the held external write, for hazard and forwarding logic.
REQ-010 SHALL have ports stall_req  out  1 (requests a pipeline freeze) and init_busy  out  1 (clear sequence active).

Function
REQ-011 SHALL implement states INIT and RUN; reset enters INIT with a 5-bit clear counter of 0.
REQ-012 In INIT, SHALL drive rf_we=1, rf_waddr=counter and rf_wdata=0, and SHALL increment the counter each cycle.
REQ-013 SHALL go from INIT to RUN after the cycle in which counter=31, so the clear takes exactly 32 cycles.
REQ-014 init_busy SHALL be 1 in INIT and 0 in RUN; in INIT, ext_ready=0 and wb_valid is ignored.
REQ-015 SHALL hold one pending entry (pend_valid, pend_reg, pend_data); in RUN, ext_ready = !pend_valid.
REQ-016 A handshake completes when ext_valid && ext_ready; the entry then loads ext_reg/ext_data and pend_valid=1 next cycle.
REQ-017 An ext_reg of 0 SHALL be accepted and discarded (pend_valid stays 0).
REQ-018 A WB write is effective when wb_valid=1 and wb_reg!=0, and always wins the port.
REQ-019 On an effective WB write, SHALL drive rf_we=1, rf_waddr=wb_reg and rf_wdata=wb_data in the same cycle (combinational, zero latency).
REQ-020 With no effective WB write and pend_valid=1, SHALL write the pending entry to the port and clear pend_valid next cycle.
REQ-021 With neither an effective WB write nor a pending entry, rf_we=0, rf_waddr=0 and rf_wdata=0.
REQ-022 If an effective WB write has wb_reg==pend_reg while pend_valid=1, the pending entry SHALL be dropped (WB is newer) and pend_valid cleared next cycle.
REQ-023 A newly accepted entry never writes in its acceptance cycle; the earliest it can write is the following cycle.
REQ-024 SHALL count wait cycles while pend_valid=1 and the entry loses to WB; the count resets to 0 when pend_valid=0.
REQ-025 SHALL set stall_req=1 (registered) when the wait count reaches STALL_LIMIT, holding it until the entry is written or dropped.
REQ-026 SHALL keep the wait counter saturating and at least 4 bits wide.
REQ-027 While stall_req=1, the pipeline deasserts wb_valid; the arbiter relies on that, with no other priority change.
REQ-028 SHALL treat accept and drain in the same cycle as impossible, since ext_ready=0 whenever pend_valid=1.

Reset
REQ-029 While rst_n=0: state=INIT, counter=0, pend_valid=0, pend_reg=0, pend_data=0, wait count=0, stall_req=0, init_busy=1, ext_ready=0.
REQ-030 During reset, the rf_* outputs SHALL follow INIT decoding (rf_we=1, rf_waddr=0, rf_wdata=0).
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abandon all state, discard the pending entry, and restart the 32-cycle clear.

Verification
REQ-032 Reset release: SHALL see rf_we=1 with rf_waddr 0..31 over 32 cycles at data 0, then init_busy=0 and ext_ready=1.
REQ-033 Idle RUN with ext_valid=1, ext_reg=5, ext_data=0xDEADBEEF: SHALL see accept, then next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, then ext_ready=1 again.
REQ-034 Pending reg 7 while WB writes regs 3,4,9,10 (STALL_LIMIT=4): SHALL see stall_req=1 after the 4th loss; bench drops wb_valid; next cycle writes reg 7; stall_req then falls to 0.
REQ-035 Pending reg 12 while WB writes reg 12 with 0x1: SHALL see the port write 0x1, pend_valid=0 next cycle, and no later write of the old data.
REQ-036 SHALL show ext_reg=0 accepted with no rf write, and wb_valid=1 with wb_reg=0 letting the pending entry drain the same cycle.
REQ-037 With rst_n pulsed low for 1 cycle while pend_valid=1, SHALL see pend_valid=0 and the clear sequence restart at rf_waddr=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: clears all 32 registers after reset, then
// merges writeback writes with a single held entry from a multi-cycle external writer.
module regfile_write_arbiter #(
  parameter int STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  ext_reg,
  input  logic [31:0] ext_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pend_valid,
  output logic [4:0]  pend_reg,
  output logic [31:0] pend_data,
  output logic        stall_req,
  output logic        init_busy
);

  localparam int WAIT_W = ($clog2(STALL_LIMIT + 1) > 4) ? $clog2(STALL_LIMIT + 1) : 4;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STALL_LIMIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  logic [4:0]          r_clearCnt;
  logic                r_pendValid;
  logic [4:0]          r_pendReg;
  logic [31:0]         r_pendData;
  logic [WAIT_W-1:0]   r_waitCnt;
  logic                r_stall;

  logic                w_run;
  logic                w_wbEff;
  logic                w_accept;
  logic                w_loadEntry;
  logic                w_entryLoses;
  logic                w_pendValidNext;
  logic [WAIT_W-1:0]   w_waitNext;

  assign w_run        = (r_state == ST_RUN);
  assign w_wbEff      = w_run && wb_valid && (wb_reg != 5'd0);
  assign ext_ready    = w_run && !r_pendValid;
  assign w_accept     = ext_valid && ext_ready;
  assign w_loadEntry  = w_accept && (ext_reg != 5'd0);
  // The entry survives only when a WB write to a different register takes the port.
  assign w_entryLoses = r_pendValid && w_wbEff && (wb_reg != r_pendReg);
  assign w_pendValidNext = w_loadEntry || w_entryLoses;

  always_comb begin
    w_waitNext = '0;
    if (w_entryLoses) begin
      w_waitNext = (r_waitCnt == {WAIT_W{1'b1}}) ? r_waitCnt : r_waitCnt + WAIT_W'(1);
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!w_run) begin
      rf_we    = 1'b1;
      rf_waddr = r_clearCnt;
    end else if (w_wbEff) begin
      rf_we    = 1'b1;
      rf_waddr = wb_reg;
      rf_wdata = wb_data;
    end else if (r_pendValid) begin
      rf_we    = 1'b1;
      rf_waddr = r_pendReg;
      rf_wdata = r_pendData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_clearCnt  <= 5'd0;
      r_pendValid <= 1'b0;
      r_pendReg   <= 5'd0;
      r_pendData  <= 32'd0;
      r_waitCnt   <= '0;
      r_stall     <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clearCnt <= r_clearCnt + 5'd1;
          if (r_clearCnt == 5'd31) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_pendValid <= w_pendValidNext;
          if (w_loadEntry) begin
            r_pendReg  <= ext_reg;
            r_pendData <= ext_data;
          end
          r_waitCnt <= w_waitNext;
          r_stall   <= w_pendValidNext && (w_waitNext >= LIMIT);
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign pend_valid = r_pendValid;
  assign pend_reg   = r_pendReg;
  assign pend_data  = r_pendData;
  assign stall_req  = r_stall;
  assign init_busy  = !w_run;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int STALL_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbValid;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        extValid;
  logic        extReady;
  logic [4:0]  extReg;
  logic [31:0] extData;
  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;
  logic        pendValid;
  logic [4:0]  pendReg;
  logic [31:0] pendData;
  logic        stallReq;
  logic        initBusy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wbValid), .wb_reg(wbReg), .wb_data(wbData),
    .ext_valid(extValid), .ext_ready(extReady), .ext_reg(extReg), .ext_data(extData),
    .rf_we(rfWe), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
    .pend_valid(pendValid), .pend_reg(pendReg), .pend_data(pendData),
    .stall_req(stallReq), .init_busy(initBusy)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } entry_t;

  // Reference model: clear progress, a queue holding at most one external write,
  // and the number of consecutive cycles that entry lost the port.
  bit     mInit;
  int     mClearIdx;
  entry_t mPend[$];
  int     mLosses;
  bit     mStall;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge: drives one cycle of inputs, checks outputs, advances the model.
  task automatic applyStimulus(input logic v, input logic [4:0] r, input logic [31:0] d,
                               input logic ev, input logic [4:0] er, input logic [31:0] ed);
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic        expReady;
    logic        wbEff;
    logic        accepted;
    wbValid = v;  wbReg = r;  wbData = d;
    extValid = ev; extReg = er; extData = ed;
    #1;
    wbEff    = v && (r != 5'd0);
    expWe    = 1'b0;
    expAddr  = 5'd0;
    expData  = 32'd0;
    expReady = 1'b0;
    if (mInit) begin
      expWe   = 1'b1;
      expAddr = 5'(mClearIdx);
    end else begin
      expReady = (mPend.size() == 0);
      if (wbEff) begin
        expWe = 1'b1; expAddr = r; expData = d;
      end else if (mPend.size() != 0) begin
        expWe = 1'b1; expAddr = mPend[0].r; expData = mPend[0].d;
      end
    end
    checkOutput("rf_we", 32'(rfWe), 32'(expWe));
    checkOutput("rf_waddr", 32'(rfWaddr), 32'(expAddr));
    checkOutput("rf_wdata", rfWdata, expData);
    checkOutput("ext_ready", 32'(extReady), 32'(expReady));
    checkOutput("init_busy", 32'(initBusy), 32'(mInit));
    checkOutput("pend_valid", 32'(pendValid), 32'(mPend.size() != 0));
    checkOutput("stall_req", 32'(stallReq), 32'(mStall));
    if (mPend.size() != 0) begin
      checkOutput("pend_reg", 32'(pendReg), 32'(mPend[0].r));
      checkOutput("pend_data", pendData, mPend[0].d);
    end
    @(posedge clk);
    if (mInit) begin
      if (mClearIdx == 31) mInit = 1'b0;
      else mClearIdx++;
    end else begin
      accepted = ev && expReady;
      if (mPend.size() != 0) begin
        if (!wbEff || r == mPend[0].r) begin
          void'(mPend.pop_front());
          mLosses = 0;
        end else begin
          mLosses++;
        end
      end
      if (accepted && er != 5'd0) mPend.push_back('{er, ed});
      mStall = (mPend.size() != 0) && (mLosses >= STALL_LIMIT);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic doReset(input int cycles);
    wbValid = 1'b0; wbReg = 5'd0; wbData = 32'd0;
    extValid = 1'b0; extReg = 5'd0; extData = 32'd0;
    rst_n = 1'b0;
    #1;
    mInit = 1'b1; mClearIdx = 0; mPend.delete(); mLosses = 0; mStall = 1'b0;
    checkOutput("rst_pend_valid", 32'(pendValid), 32'd0);
    checkOutput("rst_pend_reg", 32'(pendReg), 32'd0);
    checkOutput("rst_pend_data", pendData, 32'd0);
    checkOutput("rst_stall", 32'(stallReq), 32'd0);
    checkOutput("rst_busy", 32'(initBusy), 32'd1);
    checkOutput("rst_ready", 32'(extReady), 32'd0);
    checkOutput("rst_rf_we", 32'(rfWe), 32'd1);
    checkOutput("rst_rf_waddr", 32'(rfWaddr), 32'd0);
    checkOutput("rst_rf_wdata", rfWdata, 32'd0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        v;
    logic [4:0]  r;
    logic        ev;
    logic [4:0]  er;
    rst_n = 1'b1;
    wbValid = 1'b0; wbReg = 5'd0; wbData = 32'd0;
    extValid = 1'b0; extReg = 5'd0; extData = 32'd0;
    @(negedge clk);

    // Power-up clear sequence
    doReset(2);
    repeat (32) idle();
    checkOutput("busy_after_clear", 32'(initBusy), 32'd0);
    checkOutput("ready_after_clear", 32'(extReady), 32'd1);

    // Single external write on an idle port
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("ext5_pending", 32'(pendReg), 32'd5);
    idle();
    checkOutput("ext5_ready_again", 32'(extReady), 32'd1);

    // Pending entry starved by WB until stall
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7777);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    checkOutput("stall_before_limit", 32'(stallReq), 32'd0);
    applyStimulus(1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 32'd0);
    checkOutput("stall_at_limit", 32'(stallReq), 32'd1);
    idle();
    checkOutput("stall_released", 32'(stallReq), 32'd0);
    checkOutput("reg7_drained", 32'(pendValid), 32'd0);

    // WB to the same register supersedes the pending entry
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hBAD0_0012);
    applyStimulus(1'b1, 5'd12, 32'h1, 1'b0, 5'd0, 32'd0);
    checkOutput("reg12_dropped", 32'(pendValid), 32'd0);
    idle();
    idle();

    // Writes to register 0 from either source
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
    checkOutput("ext_r0_discarded", 32'(pendValid), 32'd0);
    idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020_2020);
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    checkOutput("wb_r0_lets_drain", 32'(pendValid), 32'd0);

    // Reset pulse with an entry pending restarts the clear
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_0909);
    checkOutput("pend_before_reset", 32'(pendValid), 32'd1);
    doReset(1);
    checkOutput("pend_after_reset", 32'(pendValid), 32'd0);
    repeat (32) idle();

    // Random traffic, with one extra reset midway
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        doReset(1);
      end
      v  = mStall ? 1'b0 : 1'($urandom_range(0, 1));
      r  = 5'($urandom_range(0, 31));
      if (mPend.size() != 0 && $urandom_range(0, 3) == 0) r = mPend[0].r;
      if ($urandom_range(0, 7) == 0) r = 5'd0;
      ev = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus(v, r, $urandom, ev, er, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
